// File: rtl/maxpool_pkg.sv
// Shared constants and types for the int8 2x2 max-pool engine: cgu geometry,
// tuser bit positions and the pooling phase encoding.
package maxpool_pkg;

  localparam int UNITS          = 8;
  localparam int GROUPS         = 2;
  localparam int COPIES         = 2;
  localparam int WORD_WIDTH     = 8;
  localparam int BITS_CONV_CORE = 5;

  localparam int I_IS_3X3             = BITS_CONV_CORE + 0;
  localparam int I_MAXPOOL_IS_MAX     = BITS_CONV_CORE + 1;
  localparam int I_MAXPOOL_IS_NOT_MAX = BITS_CONV_CORE + 2;
  localparam int TUSER_WIDTH          = BITS_CONV_CORE + 3;

  localparam int N_WORDS    = COPIES * GROUPS * UNITS;
  localparam int DATA_WIDTH = N_WORDS * WORD_WIDTH;
  // One pooled word per vertical unit pair across every (copy, group).
  localparam int N_PAIRS    = COPIES * GROUPS * (UNITS / 2);

  typedef logic signed [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

endpackage

// File: rtl/maxpool_lane_max.sv
// Combinational signed max over N independent word pairs: y[i] = max(a[i], b[i]).
module maxpool_lane_max
  import maxpool_pkg::*;
#(
  parameter int N = N_PAIRS
) (
  input  logic [N*WORD_WIDTH-1:0] a_i,
  input  logic [N*WORD_WIDTH-1:0] b_i,
  output logic [N*WORD_WIDTH-1:0] y_o
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    word_t a_w;
    word_t b_w;
    assign a_w = word_t'(a_i[i*WORD_WIDTH +: WORD_WIDTH]);
    assign b_w = word_t'(b_i[i*WORD_WIDTH +: WORD_WIDTH]);
    assign y_o[i*WORD_WIDTH +: WORD_WIDTH] = (a_w > b_w) ? a_w : b_w;
  end

endmodule

// File: rtl/axis_maxpool_engine.sv
// AXI-Stream int8 2x2 max-pool (vertical = unit pairs, horizontal = beat pairs) with PASS bypass.
// Build option MAXPOOL_SKID_BUFFER_EN: registered s_axis_tready backed by a 2-entry output skid buffer.
module axis_maxpool_engine
  import maxpool_pkg::*;
(
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tlast
);

  localparam int HALF = UNITS / 2;
  localparam int PW   = N_PAIRS * WORD_WIDTH;

  phase_t                 phase_q, phase_d;
  logic [PW-1:0]          hreg_q, hreg_d, lo_q, lo_d;
  logic [PW-1:0]          x_even, x_odd, v, h_a, h_y, pool_lo, pool_hi;
  logic [DATA_WIDTH-1:0]  pool_data, new_data;
  logic                   accept, is_pool, emit, load_new;

  logic                   out_valid_q, out_last_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [TUSER_WIDTH-1:0] out_user_q;

  // tdata holds unit 0 of (copy 0, group 0) in the MSB word; pair vectors are LSB-first.
  for (genvar cg = 0; cg < COPIES * GROUPS; cg++) begin : g_cg
    for (genvar k = 0; k < HALF; k++) begin : g_k
      localparam int P = cg * HALF + k;
      localparam int E = cg * UNITS + 2 * k;
      assign x_even[P*WORD_WIDTH +: WORD_WIDTH] = s_axis_tdata[(N_WORDS-1-E)*WORD_WIDTH +: WORD_WIDTH];
      assign x_odd[P*WORD_WIDTH +: WORD_WIDTH]  = s_axis_tdata[(N_WORDS-2-E)*WORD_WIDTH +: WORD_WIDTH];
      assign pool_data[(N_WORDS-1-(cg*UNITS+k))*WORD_WIDTH +: WORD_WIDTH]      = pool_lo[P*WORD_WIDTH +: WORD_WIDTH];
      assign pool_data[(N_WORDS-1-(cg*UNITS+HALF+k))*WORD_WIDTH +: WORD_WIDTH] = pool_hi[P*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  maxpool_lane_max #(.N(N_PAIRS)) u_vert (
    .a_i (x_even),
    .b_i (x_odd),
    .y_o (v)
  );

  // On an opening beat (PH0/PH2) the horizontal pair degenerates to max(v, v),
  // which is exactly how a tlast there closes the window.
  assign h_a = (phase_q == PH1 || phase_q == PH3) ? hreg_q : v;

  maxpool_lane_max #(.N(N_PAIRS)) u_horz (
    .a_i (h_a),
    .b_i (v),
    .y_o (h_y)
  );

  assign pool_lo  = (phase_q == PH2 || phase_q == PH3) ? lo_q : h_y;
  assign pool_hi  = (phase_q == PH2 || phase_q == PH3) ? h_y  : '0;
  assign is_pool  = s_axis_tuser[I_MAXPOOL_IS_MAX];
  assign new_data = is_pool ? pool_data : s_axis_tdata;
  assign accept   = s_axis_tvalid && s_axis_tready;
  assign load_new = accept && emit;

  always_comb begin
    phase_d = phase_q;
    hreg_d  = hreg_q;
    lo_d    = lo_q;
    emit    = 1'b0;
    if (accept) begin
      if (!is_pool) begin
        emit    = 1'b1;
        phase_d = PH0;
      end else begin
        unique case (phase_q)
          PH0: if (s_axis_tlast) emit = 1'b1;
               else begin hreg_d = v; phase_d = PH1; end
          PH1: if (s_axis_tlast) begin emit = 1'b1; phase_d = PH0; end
               else begin lo_d = h_y; phase_d = PH2; end
          PH2: if (s_axis_tlast) begin emit = 1'b1; phase_d = PH0; end
               else begin hreg_d = v; phase_d = PH3; end
          PH3: begin emit = 1'b1; phase_d = PH0; end
        endcase
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      phase_q <= PH0;
      hreg_q  <= '0;
      lo_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hreg_q  <= hreg_d;
      lo_q    <= lo_d;
    end
  end

  // Handshake: a beat moves on a port only in a cycle where valid && ready; a
  // presented output (valid, data, user, last) holds unchanged until taken.
`ifdef MAXPOOL_SKID_BUFFER_EN
  logic                   ready_q, sk_valid_q, sk_last_q;
  logic [DATA_WIDTH-1:0]  sk_data_q;
  logic [TUSER_WIDTH-1:0] sk_user_q;

  assign s_axis_tready = ready_q;

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      ready_q     <= 1'b1;
      sk_valid_q  <= 1'b0;
      sk_data_q   <= '0;
      sk_user_q   <= '0;
      sk_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (sk_valid_q) begin
      // Skid full means ready_q is low, so no new result can arrive this cycle.
      if (m_axis_tready) begin
        out_data_q <= sk_data_q;
        out_user_q <= sk_user_q;
        out_last_q <= sk_last_q;
        sk_valid_q <= 1'b0;
        ready_q    <= 1'b1;
      end
    end else if (!out_valid_q || m_axis_tready) begin
      out_valid_q <= load_new;
      if (load_new) begin
        out_data_q <= new_data;
        out_user_q <= s_axis_tuser;
        out_last_q <= s_axis_tlast;
      end
    end else if (load_new) begin
      sk_data_q  <= new_data;
      sk_user_q  <= s_axis_tuser;
      sk_last_q  <= s_axis_tlast;
      sk_valid_q <= 1'b1;
      ready_q    <= 1'b0;
    end
  end
`else
  assign s_axis_tready = m_axis_tready || !out_valid_q;

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (!out_valid_q || m_axis_tready) begin
      out_valid_q <= load_new;
      if (load_new) begin
        out_data_q <= new_data;
        out_user_q <= s_axis_tuser;
        out_last_q <= s_axis_tlast;
      end
    end
  end
`endif

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_axis_maxpool_engine.sv
// Directed bench for axis_maxpool_engine: PASS, POOL, signed, backpressure, tlast and reset cases.
module tb_axis_maxpool_engine;
  import maxpool_pkg::*;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b1;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [255:0] s_axis_tdata = '0;
  logic [7:0]   s_axis_tuser = '0;
  logic         s_axis_tlast = 1'b0;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic [255:0] m_axis_tdata;
  logic [7:0]   m_axis_tuser;
  logic         m_axis_tlast;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  bp_en    = 1'b0;
  logic [264:0] exp_q[$];

  localparam logic [7:0] U_POOL = 8'h40;
  localparam logic [7:0] U_PASS = 8'h80;

  always #5 aclk = ~aclk;

  axis_maxpool_engine dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast)
  );

  task automatic chk(input string tag, input logic [265:0] got, input logic [265:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word (cg, u) of a beat; cg = copy*GROUPS + group, unit 0 in the MSB word.
  function automatic logic [255:0] put(input logic [255:0] d, input int cg, input int u, input logic [7:0] w);
    logic [255:0] r = d;
    r[(31 - (cg*8 + u))*8 +: 8] = w;
    return r;
  endfunction

  function automatic logic signed [7:0] wd(input logic [255:0] d, input int cg, input int u);
    return d[(31 - (cg*8 + u))*8 +: 8];
  endfunction

  // Beat n: unit u of every (copy, group) holds n*10 + u - 20.
  function automatic logic [255:0] pat(input int n);
    logic [255:0] r = '0;
    for (int cg = 0; cg < 4; cg++)
      for (int u = 0; u < 8; u++) r = put(r, cg, u, 8'(n*10 + u - 20));
    return r;
  endfunction

  // Lanes 0..3 = 2k+lo, lanes 4..7 = 2k+hi (or 0 when hz).
  function automatic logic [255:0] exp_pat(input int lo, input int hi, input bit hz);
    logic [255:0] r = '0;
    for (int cg = 0; cg < 4; cg++)
      for (int k = 0; k < 4; k++) begin
        r = put(r, cg, k, 8'(2*k + lo));
        r = put(r, cg, 4 + k, hz ? 8'h00 : 8'(2*k + hi));
      end
    return r;
  endfunction

  function automatic logic signed [7:0] max_win(input logic [255:0] a, input logic [255:0] b, input int cg, input int k);
    logic signed [7:0] m = wd(a, cg, 2*k);
    if (wd(a, cg, 2*k+1) > m) m = wd(a, cg, 2*k+1);
    if (wd(b, cg, 2*k)   > m) m = wd(b, cg, 2*k);
    if (wd(b, cg, 2*k+1) > m) m = wd(b, cg, 2*k+1);
    return m;
  endfunction

  function automatic logic [255:0] model4(input logic [255:0] b0, input logic [255:0] b1,
                                          input logic [255:0] b2, input logic [255:0] b3);
    logic [255:0] r = '0;
    for (int cg = 0; cg < 4; cg++)
      for (int k = 0; k < 4; k++) begin
        r = put(r, cg, k, max_win(b0, b1, cg, k));
        r = put(r, cg, 4 + k, max_win(b2, b3, cg, k));
      end
    return r;
  endfunction

  task automatic push_exp(input logic [255:0] d, input logic [7:0] u, input logic l);
    exp_q.push_back({d, u, l});
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [7:0] u, input logic l);
    bit ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      ok = s_axis_tready;
      @(negedge aclk);
    end
    if (!ok) chk("s_ready_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge aclk);
    aresetn       = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(negedge aclk);
      #1;
      chk("rst_valid", m_axis_tvalid, 0);
      chk("rst_data", m_axis_tdata, 0);
      chk("rst_user", m_axis_tuser, 0);
      chk("rst_last", m_axis_tlast, 0);
    end
    aresetn = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge aclk);
    chk("drain", exp_q.size(), 0);
  endtask

  // Ready driver: always 1 unless a backpressure phase is active.
  initial forever begin
    @(negedge aclk);
    m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard: compare each taken beat in order, and hold-stability while stalled.
  initial begin
    logic [265:0] cur;
    logic [265:0] held = '0;
    logic [264:0] e;
    bit held_v = 1'b0;
    forever begin
      @(negedge aclk);
      #1;
      cur = {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast};
      if (held_v && !aresetn) chk("stall_stable", cur, held);
      held_v = m_axis_tvalid && !m_axis_tready;
      held   = cur;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", m_axis_tdata, e[264:9]);
          chk("out_user", m_axis_tuser, e[8:1]);
          chk("out_last", m_axis_tlast, e[0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] b[4];
    logic [255:0] d;
    logic [7:0]   u;

    do_reset(4);

    // 1: PASS beats, 1-cycle latency, tlast on the third only.
    push_exp({32{8'h05}}, U_PASS | 8'd3, 1'b0);
    push_exp({32{8'h80}}, U_PASS | 8'd3, 1'b0);
    push_exp({32{8'h7F}}, U_PASS | 8'd3, 1'b1);
    send_beat({32{8'h05}}, U_PASS | 8'd3, 1'b0);
    #1;
    chk("pass_lat_valid", m_axis_tvalid, 1);
    chk("pass_lat_data", m_axis_tdata, {32{8'h05}});
    send_beat({32{8'h80}}, U_PASS | 8'd3, 1'b0);
    send_beat({32{8'h7F}}, U_PASS | 8'd3, 1'b1);
    drain();

    // 2: basic POOL; lo lanes 11,13,15,17 and hi lanes 31,33,35,37.
    push_exp(exp_pat(11, 31, 1'b0), U_POOL | 8'd4, 1'b0);
    for (int n = 2; n <= 5; n++) send_beat(pat(n), U_POOL | 8'(n - 1), 1'b0);
    drain();

    // 3: signed compares; the single -1 sits at (copy1, group0) unit 5 of beat 2.
    d = {32{8'h80}};
    push_exp(put(d, 2, 6, 8'hFF), U_POOL | U_PASS, 1'b0);
    send_beat(d, U_POOL, 1'b0);
    send_beat(d, U_POOL, 1'b0);
    send_beat(put(d, 2, 5, 8'hFF), U_POOL, 1'b0);
    send_beat(d, U_POOL | U_PASS, 1'b0);
    drain();

    // 4: random data under random output backpressure, 16 windows.
    bp_en = 1'b1;
    for (int w = 0; w < 16; w++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 8; j++) b[i][j*32 +: 32] = $urandom;
      u = 8'($urandom) | U_POOL;
      u[0] = 1'b0;
      push_exp(model4(b[0], b[1], b[2], b[3]), u, 1'b0);
      for (int i = 0; i < 3; i++) send_beat(b[i], U_POOL | 8'($urandom_range(0, 31)), 1'b0);
      send_beat(b[3], u, 1'b0);
    end
    drain();
    bp_en = 1'b0;

    // 5: tlast at ph0, ph1, ph2, then a full window to show phase returned to 0.
    push_exp(exp_pat(1, 0, 1'b1), U_POOL, 1'b1);
    send_beat(pat(2), U_POOL, 1'b1);
    push_exp(exp_pat(11, 0, 1'b1), U_POOL | 8'd1, 1'b1);
    send_beat(pat(2), U_POOL, 1'b0);
    send_beat(pat(3), U_POOL | 8'd1, 1'b1);
    push_exp(exp_pat(11, 21, 1'b0), U_POOL | 8'd2, 1'b1);
    send_beat(pat(2), U_POOL, 1'b0);
    send_beat(pat(3), U_POOL, 1'b0);
    send_beat(pat(4), U_POOL | 8'd2, 1'b1);
    push_exp(exp_pat(11, 31, 1'b0), U_POOL, 1'b0);
    for (int n = 2; n <= 5; n++) send_beat(pat(n), U_POOL, 1'b0);
    drain();

    // PASS in the middle of a window discards the partial pool.
    push_exp(pat(7), U_PASS, 1'b0);
    push_exp(exp_pat(11, 31, 1'b0), U_POOL, 1'b0);
    send_beat(pat(2), U_POOL, 1'b0);
    send_beat(pat(3), U_POOL, 1'b0);
    send_beat(pat(7), U_PASS, 1'b0);
    for (int n = 2; n <= 5; n++) send_beat(pat(n), U_POOL, 1'b0);
    drain();

    // 6: reset after two stale beats; only the fresh window may appear.
    send_beat({32{8'd100}}, U_POOL, 1'b0);
    send_beat({32{8'd100}}, U_POOL, 1'b0);
    do_reset(3);
    push_exp(exp_pat(11, 31, 1'b0), U_POOL | 8'd9, 1'b0);
    for (int n = 2; n <= 5; n++) send_beat(pat(n), U_POOL | 8'd9, 1'b0);
    drain();

    repeat (4) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
